dbf_ch_dyn: RTL and testbench
=============================

# dbf_ch_dyn

Parametrised, dynamically focused receive beamforming channel. It delays one channel's echo samples by a per-focal-zone coarse + fractional delay and linearly interpolates the fine delay. It then apodises the result and emits a full-precision, valid-qualified sample stream to the channel-summing tree. Unlike the fixed-delay channels, the delay profile changes during the line: each group of ZONE_LEN samples uses its own delay-LUT entry. The block also has an explicit line state machine with a completion flag.

## Interface
Parameters:
- INPUT_WD, 14: signed input sample width.
- APO_WD, 16: signed apodisation coefficient width.
- CD_WD, 8: coarse-delay width; the delay line depth is 2^CD_WD samples.
- FRAC_WD, 4: fractional-delay width, in units of 1/2^FRAC_WD sample.
- ADDR_WD, 6: delay-LUT address width; the LUT holds 2^ADDR_WD zone entries.
- ZONE_LEN, 64: accepted samples per focal zone.
- LINE_LEN, 4096: accepted samples per receive line.
- OUT_WD, 32: output width; must be ≥ INPUT_WD+1+APO_WD.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- tx_en, in, 1: transmit window; while it is high, input samples are ignored.
- start, in, 1: one-cycle pulse that begins a receive line.
- din, in, INPUT_WD: signed echo sample.
- din_valid, in, 1: din qualifier.
- apo_din, in, APO_WD: signed apodisation coefficient, captured on start.
- lut_we, in, 1: delay-LUT write enable.
- lut_addr, in, ADDR_WD: delay-LUT write address (zone index).
- lut_wdata, in, CD_WD+FRAC_WD: delay-LUT entry, laid out as {coarse, frac}.
- dout, out, OUT_WD: signed apodised output.
- dout_valid, out, 1: dout qualifier.
- line_done, out, 1: one-cycle pulse after the last output of a line.
- busy, out, 1: high in RUN and FLUSH.

## Operation
- Accepted sample: din_valid=1, tx_en=0 and state RUN. Its index n counts from 0 at each start.
- State machine:
  - IDLE -> RUN on start: clear n, wr_ptr and zone; capture apo_din; load LUT[0] as the active delay.
  - RUN -> FLUSH when sample n=LINE_LEN-1 is accepted.
  - FLUSH -> IDLE after the pipeline drains; line_done pulses with the final dout_valid.
- start in RUN or FLUSH aborts the line. In-flight pipeline data is discarded (dout_valid forced to 0 that cycle) and RUN restarts as from IDLE.
- Delay line: circular buffer of 2^CD_WD samples. The sample is written at wr_ptr, which then increments modulo 2^CD_WD (wrap is normal).
- Zone update: on the acceptance that makes n a multiple of ZONE_LEN, zone increments and LUT[zone] becomes active for that sample onward. zone saturates at 2^ADDR_WD-1.
- Coarse clamp: an active coarse value c > 2^CD_WD-2 is clamped to 2^CD_WD-2.
- Taps per accepted sample n: x0=x[n-c], x1=x[n-c-1].
- Warm-up: if n < c+1, the interpolated value is 0 but dout_valid still asserts, which keeps line alignment.
- Fine delay: y = x0 + (((x1-x0)*frac) >>> FRAC_WD).
  - Arithmetic right shift (floor).
  - x1-x0 is INPUT_WD+1 bits; y is INPUT_WD+1 bits signed and never overflows.
- Apodisation: p = y*apo, full precision (INPUT_WD+1+APO_WD bits). dout is p sign-extended to OUT_WD; no rounding or saturation.
- LUT: single write port, with writes legal in any state. On the same-cycle write and zone load of one address, the load returns the old entry (read-first).
- tx_en=1 in RUN: samples are ignored, and n, wr_ptr and zone hold.

## Timing
- Reset values: dout=0, dout_valid=0, line_done=0, busy=0. State goes to IDLE; n, wr_ptr, zone, the active delay and apo are cleared; the LUT contents are undefined.
- Reset mid-line: outputs return to reset values immediately (asynchronous assert); the next line requires start.
- Latency: a sample accepted at edge k appears with dout_valid=1 at edge k+4. Pipeline:
  - buffer write/tap read;
  - difference × frac;
  - add x0;
  - × apo and output register.
- Throughput: one sample per clock; dout_valid follows accepted samples exactly, including gaps.
- busy rises at the edge after start; line_done rises 4 cycles after the last acceptance and busy falls the same edge.
- dout holds its value when dout_valid=0.

## Test plan
- Reset: assert rst_n=0 mid-line -> dout=0, dout_valid=0, busy=0 asynchronously; after release, no output without start.
- Integer delay: LUT[0]={3,0}, apo=2, din=n, continuous valid -> dout=0 for n≤3, dout=2(n-3) for n≥4, each 4 cycles after acceptance.
- Fractional delay: LUT[0]={2,8}, FRAC_WD=4, apo=1, din=16n -> dout=16n-40 for n≥3; with din=-16n -> dout=-16n+40.
- Zone switch: ZONE_LEN=64, LUT[0]={1,0}, LUT[1]={5,0}, din=n -> dout=n-1 for n=2..63, dout=n-5 for n=64..; wr_ptr wraps past 255 with no glitch (LINE_LEN=512).
- Gating and length: tx_en pulses high and din_valid gaps mid-line -> no dout_valid for ignored samples and the sequence continues unchanged; exactly LINE_LEN valid outputs; a single line_done coincides with the last one.
- Abort: start at n=100 -> no dout_valid for the discarded in-flight samples; n restarts at 0 with LUT[0] and the newly captured apo.

Source files
------------

// File: rtl/dbf_ch_dyn.sv
// Dynamically focused receive beamforming channel: per-zone coarse/fractional delay,
// linear interpolation and apodisation, with a RUN/FLUSH line state machine.
module dbf_ch_dyn #(
    parameter int INPUT_WD = 14,
    parameter int APO_WD   = 16,
    parameter int CD_WD    = 8,
    parameter int FRAC_WD  = 4,
    parameter int ADDR_WD  = 6,
    parameter int ZONE_LEN = 64,
    parameter int LINE_LEN = 4096,
    parameter int OUT_WD   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_en,
    input  logic                        start,
    input  logic signed [INPUT_WD-1:0]  din,
    input  logic                        din_valid,
    input  logic signed [APO_WD-1:0]    apo_din,
    input  logic                        lut_we,
    input  logic [ADDR_WD-1:0]          lut_addr,
    input  logic [CD_WD+FRAC_WD-1:0]    lut_wdata,
    output logic signed [OUT_WD-1:0]    dout,
    output logic                        dout_valid,
    output logic                        line_done,
    output logic                        busy
);
    localparam int XW    = INPUT_WD + 1;
    localparam int MW    = XW + FRAC_WD + 1;
    localparam int PW    = XW + APO_WD;
    localparam int NW    = $clog2(LINE_LEN + 1);
    localparam int ZCW   = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;
    localparam int DEPTH = 2 ** CD_WD;
    localparam int LW    = CD_WD + FRAC_WD;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    function automatic logic [CD_WD-1:0] f_clamp(input logic [CD_WD-1:0] c);
        return (c > CD_WD'(DEPTH - 2)) ? CD_WD'(DEPTH - 2) : c;
    endfunction

    // Floor shift keeps the interpolant inside [x0, x1]; the sum always fits XW bits.
    function automatic logic signed [XW-1:0] f_interp(input logic signed [INPUT_WD-1:0] x0,
                                                      input logic signed [MW-1:0] prod);
        logic signed [MW-1:0] s;
        s = MW'(x0) + (prod >>> FRAC_WD);
        return s[XW-1:0];
    endfunction

    function automatic logic signed [OUT_WD-1:0] f_apodise(input logic signed [XW-1:0] y,
                                                           input logic signed [APO_WD-1:0] a);
        logic signed [PW-1:0] p;
        p = PW'(y) * PW'(a);
        return OUT_WD'(p);
    endfunction

    state_t                     r_state;
    logic [NW-1:0]              r_n;
    logic [ZCW-1:0]             r_zcnt;
    logic [ADDR_WD-1:0]         r_zone;
    logic [CD_WD-1:0]           r_wr_ptr;
    logic [LW-1:0]              r_delay;
    logic signed [APO_WD-1:0]   r_apo;
    logic [LW-1:0]              r_lut [2**ADDR_WD];
    logic signed [INPUT_WD-1:0] r_mem [DEPTH];

    logic                       r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
    logic                       r_last_p0, r_last_p1, r_last_p2, r_last_p3;
    logic signed [INPUT_WD-1:0] r_din_p0;
    logic [CD_WD-1:0]           r_wa_p0, r_c_p0;
    logic [FRAC_WD-1:0]         r_frac_p0, r_frac_p1;
    logic                       r_warm_p0;
    logic signed [INPUT_WD-1:0] r_x0_p1, r_x1_p1, r_x0_p2;
    logic signed [MW-1:0]       r_prod_p2;
    logic signed [XW-1:0]       r_y_p3;
    logic signed [OUT_WD-1:0]   r_dout;
    logic                       r_dout_valid, r_line_done;

    logic                       w_acc, w_zbound, w_last;
    logic [ADDR_WD-1:0]         w_zone_nx;
    logic [LW-1:0]              w_delay;
    logic [CD_WD-1:0]           w_c, w_ra0, w_ra1;

    // The delay for a zone-boundary sample comes straight from the LUT so it applies to that sample.
    assign w_acc     = (r_state == S_RUN) && din_valid && !tx_en && !start;
    assign w_zbound  = (r_zcnt == '0) && (r_n != '0);
    assign w_zone_nx = (&r_zone) ? r_zone : r_zone + ADDR_WD'(1);
    assign w_delay   = w_zbound ? r_lut[w_zone_nx] : r_delay;
    assign w_c       = f_clamp(w_delay[LW-1:FRAC_WD]);
    assign w_last    = (r_n == NW'(LINE_LEN - 1));
    assign w_ra0     = r_wa_p0 - r_c_p0;
    assign w_ra1     = w_ra0 - CD_WD'(1);

    always_ff @(posedge clk) begin
        if (lut_we)
            r_lut[lut_addr] <= lut_wdata;
    end

    always_ff @(posedge clk) begin
        // p0: accepted sample, write address and active delay
        r_din_p0  <= din;
        r_wa_p0   <= r_wr_ptr;
        r_c_p0    <= w_c;
        r_frac_p0 <= w_delay[FRAC_WD-1:0];
        r_warm_p0 <= (32'(r_n) <= 32'(w_c));
        // p1: buffer write and tap read (zero coarse delay bypasses the buffer)
        if (r_vld_p0)
            r_mem[r_wa_p0] <= r_din_p0;
        r_x0_p1   <= r_warm_p0 ? '0 : ((r_c_p0 == '0) ? r_din_p0 : r_mem[w_ra0]);
        r_x1_p1   <= r_warm_p0 ? '0 : r_mem[w_ra1];
        r_frac_p1 <= r_frac_p0;
        // p2: difference times fraction
        r_prod_p2 <= (MW'(r_x1_p1) - MW'(r_x0_p1)) * MW'($signed({1'b0, r_frac_p1}));
        r_x0_p2   <= r_x0_p1;
        // p3: add x0
        r_y_p3    <= f_interp(r_x0_p2, r_prod_p2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_zcnt       <= '0;
            r_zone       <= '0;
            r_wr_ptr     <= '0;
            r_delay      <= '0;
            r_apo        <= '0;
            r_vld_p0     <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_vld_p2     <= 1'b0;
            r_vld_p3     <= 1'b0;
            r_last_p0    <= 1'b0;
            r_last_p1    <= 1'b0;
            r_last_p2    <= 1'b0;
            r_last_p3    <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_line_done  <= 1'b0;
        end else if (start) begin
            r_state      <= S_RUN;
            r_n          <= '0;
            r_zcnt       <= '0;
            r_zone       <= '0;
            r_wr_ptr     <= '0;
            r_delay      <= r_lut[0];
            r_apo        <= apo_din;
            r_vld_p0     <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_vld_p2     <= 1'b0;
            r_vld_p3     <= 1'b0;
            r_last_p0    <= 1'b0;
            r_last_p1    <= 1'b0;
            r_last_p2    <= 1'b0;
            r_last_p3    <= 1'b0;
            r_dout_valid <= 1'b0;
            r_line_done  <= 1'b0;
        end else begin
            r_vld_p0     <= w_acc;
            r_vld_p1     <= r_vld_p0;
            r_vld_p2     <= r_vld_p1;
            r_vld_p3     <= r_vld_p2;
            r_last_p0    <= w_acc && w_last;
            r_last_p1    <= r_last_p0;
            r_last_p2    <= r_last_p1;
            r_last_p3    <= r_last_p2;
            // output stage: apodise and register
            r_dout_valid <= r_vld_p3;
            r_line_done  <= r_vld_p3 && r_last_p3;
            if (r_vld_p3)
                r_dout <= f_apodise(r_y_p3, r_apo);
            if (w_acc) begin
                r_n      <= r_n + NW'(1);
                r_zcnt   <= (r_zcnt == ZCW'(ZONE_LEN - 1)) ? '0 : r_zcnt + ZCW'(1);
                r_wr_ptr <= r_wr_ptr + CD_WD'(1);
                if (w_zbound) begin
                    r_zone  <= w_zone_nx;
                    r_delay <= w_delay;
                end
            end
            case (r_state)
                S_RUN:   if (w_acc && w_last) r_state <= S_FLUSH;
                S_FLUSH: if (r_vld_p3 && r_last_p3) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign line_done  = r_line_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_dbf_ch_dyn.sv
// Directed bench for dbf_ch_dyn: reset, integer/fractional delay, zones, gating, abort.
`timescale 1ns/1ps
module tb_dbf_ch_dyn;
    localparam int IW = 14, AW = 16, CW = 8, FW = 4, ADW = 6, ZL = 64, LL = 512, OW = 32;

    logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, start = 1'b0, din_valid = 1'b0, lut_we = 1'b0;
    logic signed [IW-1:0] din = '0;
    logic signed [AW-1:0] apo_din = '0;
    logic [ADW-1:0]       lut_addr = '0;
    logic [CW+FW-1:0]     lut_wdata = '0;
    logic signed [OW-1:0] dout;
    logic                 dout_valid, line_done, busy;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    logic signed [OW-1:0] cap_d [1024];
    int cap_c [1024];
    int cap_n = 0;
    int acc_c [1024];
    int acc_n = 0;
    int ld_cnt = 0, ld_cyc = 0, ld_idx = -1;
    logic ld_busy = 1'b0, ld_vld = 1'b0;
    int hold_err = 0;
    logic signed [OW-1:0] prev_d = '0;
    int pre_cap = 0;

    dbf_ch_dyn #(.INPUT_WD(IW), .APO_WD(AW), .CD_WD(CW), .FRAC_WD(FW), .ADDR_WD(ADW),
                 .ZONE_LEN(ZL), .LINE_LEN(LL), .OUT_WD(OW)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start), .din(din),
        .din_valid(din_valid), .apo_din(apo_din), .lut_we(lut_we), .lut_addr(lut_addr),
        .lut_wdata(lut_wdata), .dout(dout), .dout_valid(dout_valid),
        .line_done(line_done), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (cap_n < 1024) begin
                cap_d[cap_n] = dout;
                cap_c[cap_n] = cyc;
            end
            cap_n++;
        end else if (dout !== prev_d) begin
            hold_err++;
        end
        prev_d = dout;
        if (line_done === 1'b1) begin
            ld_cnt++;
            ld_cyc  = cyc;
            ld_idx  = cap_n - 1;
            ld_busy = busy;
            ld_vld  = dout_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_set(input int a, input int c, input int f);
        lut_we = 1'b1; lut_addr = ADW'(a); lut_wdata = {CW'(c), FW'(f)};
        tick();
        lut_we = 1'b0;
    endtask

    task automatic lut_fill(input int c, input int f);
        for (int a = 0; a < 2**ADW; a++) lut_set(a, c, f);
    endtask

    task automatic send(input int d, input logic v, input logic t);
        din = IW'(d); din_valid = v; tx_en = t;
        if (v && !t && acc_n < 1024) begin
            acc_c[acc_n] = cyc + 1;
            acc_n++;
        end
        tick();
    endtask

    task automatic do_start(input int apo);
        start = 1'b1; apo_din = AW'(apo); din_valid = 1'b0; tx_en = 1'b0;
        tick();
        start = 1'b0;
        pre_cap = cap_n; cap_n = 0; ld_cnt = 0; ld_idx = -1; acc_n = 0; hold_err = 0;
    endtask

    task automatic idle_wait();
        int k = 0;
        din_valid = 1'b0; tx_en = 1'b0;
        while (ld_cnt == 0 && k < 40) begin tick(); k++; end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL rst_dout: got %0d want 0", dout); end
        n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
        n_chk++; if (line_done !== 1'b0) begin n_fail++; $display("FAIL rst_line_done: got %b want 0", line_done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick();
        cap_n = 0;
        for (int i = 0; i < 10; i++) send(i + 1, 1'b1, 1'b0);
        din_valid = 1'b0;
        repeat (6) tick();
        n_chk++; if (cap_n !== 0) begin n_fail++; $display("FAIL rst_no_start_out: got %0d outputs want 0", cap_n); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_start_busy: got %b want 0", busy); end
    endtask

    task automatic test_integer_delay();
        int bad = 0;
        lut_fill(3, 0);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL int_busy_idle: got %b want 0", busy); end
        do_start(2);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL int_busy_rise: got %b want 1", busy); end
        for (int n = 0; n < LL; n++) send(n, 1'b1, 1'b0);
        idle_wait();
        n_chk++; if (cap_n !== LL) begin n_fail++; $display("FAIL int_count: got %0d want %0d", cap_n, LL); end
        for (int n = 0; n < LL; n++) begin
            int want;
            want = (n <= 3) ? 0 : 2 * (n - 3);
            n_chk++;
            if (cap_d[n] !== OW'(want)) begin
                n_fail++; bad++;
                if (bad <= 4) $display("FAIL int_dout[%0d]: got %0d want %0d", n, cap_d[n], want);
            end
        end
        n_chk++; if (cap_c[0] - acc_c[0] !== 4) begin n_fail++; $display("FAIL int_latency: got %0d want 4", cap_c[0] - acc_c[0]); end
        n_chk++; if (ld_cnt !== 1) begin n_fail++; $display("FAIL int_line_done_cnt: got %0d want 1", ld_cnt); end
        n_chk++; if (ld_idx !== LL - 1 || ld_vld !== 1'b1) begin n_fail++; $display("FAIL int_line_done_pos: got idx %0d vld %b want %0d 1", ld_idx, ld_vld, LL - 1); end
        n_chk++; if (ld_cyc - acc_c[LL-1] !== 4) begin n_fail++; $display("FAIL int_line_done_lat: got %0d want 4", ld_cyc - acc_c[LL-1]); end
        n_chk++; if (ld_busy !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL int_busy_fall: got %b/%b want 0/0", ld_busy, busy); end
    endtask

    task automatic test_fractional();
        lut_fill(2, 8);
        for (int m = 0; m < 3; m++) begin
            int bad = 0;
            do_start(1);
            for (int n = 0; n < LL; n++) send((m == 0) ? 16 * n : (m == 1) ? -16 * n : 3 * n, 1'b1, 1'b0);
            idle_wait();
            n_chk++; if (cap_n !== LL) begin n_fail++; $display("FAIL frac%0d_count: got %0d want %0d", m, cap_n, LL); end
            for (int n = 0; n < LL; n++) begin
                int want;
                if (n <= 2) want = 0;
                else want = (m == 0) ? 16 * n - 40 : (m == 1) ? -16 * n + 40 : 3 * n - 8;
                n_chk++;
                if (cap_d[n] !== OW'(want)) begin
                    n_fail++; bad++;
                    if (bad <= 4) $display("FAIL frac%0d_dout[%0d]: got %0d want %0d", m, n, cap_d[n], want);
                end
            end
        end
    endtask

    task automatic test_zone_switch();
        int bad = 0;
        lut_set(0, 1, 0);
        for (int a = 1; a < 5; a++) lut_set(a, 5, 0);
        for (int a = 5; a < 2**ADW; a++) lut_set(a, 255, 0);
        do_start(1);
        for (int n = 0; n < LL; n++) send(n, 1'b1, 1'b0);
        idle_wait();
        n_chk++; if (cap_n !== LL) begin n_fail++; $display("FAIL zone_count: got %0d want %0d", cap_n, LL); end
        for (int n = 0; n < LL; n++) begin
            int want;
            if (n <= 1) want = 0;
            else if (n < 64) want = n - 1;
            else if (n < 320) want = n - 5;
            else want = n - 254;
            n_chk++;
            if (cap_d[n] !== OW'(want)) begin
                n_fail++; bad++;
                if (bad <= 4) $display("FAIL zone_dout[%0d]: got %0d want %0d", n, cap_d[n], want);
            end
        end
    endtask

    task automatic test_gating();
        int bad = 0;
        int n = 0;
        int i = 0;
        lut_fill(3, 0);
        do_start(1);
        while (n < LL) begin
            if (i % 7 == 2) send(-5, 1'b0, 1'b0);
            else if (i % 7 == 5) send(-999, 1'b1, 1'b1);
            else begin send(n, 1'b1, 1'b0); n++; end
            i++;
        end
        idle_wait();
        n_chk++; if (cap_n !== LL) begin n_fail++; $display("FAIL gate_count: got %0d want %0d", cap_n, LL); end
        for (int k = 0; k < LL; k++) begin
            int want;
            want = (k <= 3) ? 0 : k - 3;
            n_chk++;
            if (cap_d[k] !== OW'(want)) begin
                n_fail++; bad++;
                if (bad <= 4) $display("FAIL gate_dout[%0d]: got %0d want %0d", k, cap_d[k], want);
            end
        end
        n_chk++; if (ld_cnt !== 1 || ld_idx !== LL - 1) begin n_fail++; $display("FAIL gate_line_done: got cnt %0d idx %0d want 1 %0d", ld_cnt, ld_idx, LL - 1); end
        n_chk++; if (hold_err !== 0) begin n_fail++; $display("FAIL gate_dout_hold: got %0d changes want 0", hold_err); end
    endtask

    task automatic test_abort();
        int bad = 0;
        lut_fill(5, 0);
        lut_set(0, 3, 0);
        do_start(2);
        for (int n = 0; n < 100; n++) send(n, 1'b1, 1'b0);
        do_start(3);
        n_chk++; if (pre_cap !== 96) begin n_fail++; $display("FAIL abort_pre_count: got %0d want 96", pre_cap); end
        n_chk++; if (cap_d[95] !== OW'(180)) begin n_fail++; $display("FAIL abort_pre_last: got %0d want 180", cap_d[95]); end
        for (int n = 0; n < LL; n++) send(n, 1'b1, 1'b0);
        idle_wait();
        n_chk++; if (cap_n !== LL) begin n_fail++; $display("FAIL abort_count: got %0d want %0d", cap_n, LL); end
        n_chk++; if (cap_c[0] - acc_c[0] !== 4) begin n_fail++; $display("FAIL abort_latency: got %0d want 4", cap_c[0] - acc_c[0]); end
        for (int n = 0; n < LL; n++) begin
            int want;
            if (n <= 3) want = 0;
            else if (n < 64) want = 3 * (n - 3);
            else want = 3 * (n - 5);
            n_chk++;
            if (cap_d[n] !== OW'(want)) begin
                n_fail++; bad++;
                if (bad <= 4) $display("FAIL abort_dout[%0d]: got %0d want %0d", n, cap_d[n], want);
            end
        end
        n_chk++; if (ld_cnt !== 1) begin n_fail++; $display("FAIL abort_line_done: got %0d want 1", ld_cnt); end
    endtask

    task automatic test_reset_midline();
        lut_fill(3, 0);
        do_start(2);
        for (int n = 0; n < 50; n++) send(n, 1'b1, 1'b0);
        n_chk++; if (dout_valid !== 1'b1 || dout === '0) begin n_fail++; $display("FAIL mid_pre: got vld %b dout %0d want 1 nonzero", dout_valid, dout); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL mid_rst_dout: got %0d want 0", dout); end
        n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld: got %b want 0", dout_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        din_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cap_n = 0;
        for (int n = 0; n < 20; n++) send(n, 1'b1, 1'b0);
        din_valid = 1'b0;
        repeat (6) tick();
        n_chk++; if (cap_n !== 0) begin n_fail++; $display("FAIL mid_no_start_out: got %0d want 0", cap_n); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_start_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_integer_delay();
        test_fractional();
        test_zone_switch();
        test_gating();
        test_abort();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
